axi_bresp_router: RTL and testbench

Write-response return path for one shared slave port of the AXI4 interconnect. The request-side round-robin arbiter grants one of N masters onto the slave's AW channel. This block records which master won each accepted AW transfer, in order, and steers the slave's B responses back to that master. It uses a one-entry registered output stage with full valid/ready handshaking on both sides.

---
 rtl/axi_ic_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 46 ++++
 rtl/axi_bresp_router.sv | 138 +++++++++++++
 tb/tb_axi_bresp_router.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared interconnect types: B response codes, the write-tracking entry and
// a lowest-set-bit index helper used to turn a grant vector into a master index.
package axi_ic_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  // Field widths sized for the largest supported configuration; users slice
  // down to their actual master-index and ID widths.
  localparam int TRK_IDX_W = 8;
  localparam int TRK_ID_W  = 16;

  typedef struct packed {
    logic [TRK_IDX_W-1:0] idx;
    logic [TRK_ID_W-1:0]  id;
  } trk_entry_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [TRK_IDX_W-1:0] onehot_to_idx(input logic [255:0] v);
    logic [TRK_IDX_W-1:0] r;
    r = '0;
    for (int i = 255; i >= 0; i--) begin
      if (v[i]) r = TRK_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. The caller guarantees pop only
// when non-empty and push only when not full or popping in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointer advance; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = CW'(wr_ptr - rd_ptr);

endmodule

// File: rtl/axi_bresp_router.sv
// B-channel return router for one shared slave port. Records the winning
// master of each accepted AW transfer in order and steers slave B responses
// back through a one-entry registered output stage.
// Optional feature: define AXI_BRESP_ID_CHECK_EN to store AWID per entry and
// flag BID mismatches on err_id_mismatch; otherwise that output is tied low.
module axi_bresp_router
  import axi_ic_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 8,
  parameter int ID_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N-1:0]                gnt,
  input  logic                        accept,
  input  logic [ID_W-1:0]             aw_id,
  output logic                        full,
  output logic [$clog2(DEPTH+1)-1:0]  outstanding,
  input  logic                        s_bvalid,
  output logic                        s_bready,
  input  logic [ID_W-1:0]             s_bid,
  input  logic [1:0]                  s_bresp,
  output logic [N-1:0]                m_bvalid,
  input  logic [N-1:0]                m_bready,
  output logic [ID_W-1:0]             m_bid,
  output logic [1:0]                  m_bresp,
  output logic                        err_overflow,
  output logic                        err_unexpected,
  output logic                        err_id_mismatch
);

  localparam int IDX_W = $clog2(N);
`ifdef AXI_BRESP_ID_CHECK_EN
  localparam int FW = IDX_W + ID_W;
`else
  localparam int FW = IDX_W;
`endif

  trk_entry_t        ent_in;
  logic [FW-1:0]     fifo_din;
  logic [FW-1:0]     fifo_dout;
  logic [IDX_W-1:0]  head_idx;
  logic              empty;
  logic              push;
  logic              pop;
  logic              grant_any;

  logic              out_v;
  logic [IDX_W-1:0]  out_idx;
  logic [ID_W-1:0]   out_bid;
  resp_e             out_bresp;

  assign grant_any = |gnt;
  assign pop       = s_bvalid && s_bready;
  // A full FIFO still takes the push when the head leaves in the same cycle
  assign push      = accept && grant_any && (!full || pop);
  assign s_bready  = !empty && (!out_v || m_bready[out_idx]);

  // Build the tracking entry from the grant and AWID
  always_comb begin
    ent_in     = '0;
    ent_in.idx = onehot_to_idx(256'(gnt));
    ent_in.id  = TRK_ID_W'(aw_id);
  end

`ifdef AXI_BRESP_ID_CHECK_EN
  logic [ID_W-1:0] head_id;
  assign fifo_din = {ent_in.idx[IDX_W-1:0], ent_in.id[ID_W-1:0]};
  assign head_idx = fifo_dout[FW-1 -: IDX_W];
  assign head_id  = fifo_dout[ID_W-1:0];
`else
  assign fifo_din = ent_in.idx[IDX_W-1:0];
  assign head_idx = fifo_dout;
`endif

  logic unused_ent;
  assign unused_ent = ^ent_in;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_trk_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

  // Output stage: capture on slave handshake, release on the selected master's ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_v     <= 1'b0;
      out_idx   <= '0;
      out_bid   <= '0;
      out_bresp <= OKAY;
    end else if (pop) begin
      out_v     <= 1'b1;
      out_idx   <= head_idx;
      out_bid   <= s_bid;
      out_bresp <= resp_e'(s_bresp);
    end else if (out_v && m_bready[out_idx]) begin
      out_v     <= 1'b0;
    end
  end

  // Steer valid to the recorded master only
  always_comb begin
    m_bvalid          = '0;
    m_bvalid[out_idx] = out_v;
  end

  assign m_bid          = out_bid;
  assign m_bresp        = out_bresp;
  assign err_unexpected = s_bvalid && empty;

  // Registered overflow pulse: dropped accept while full with no pop
  always_ff @(posedge clk) begin
    if (!rst_n) err_overflow <= 1'b0;
    else        err_overflow <= accept && grant_any && full && !pop;
  end

`ifdef AXI_BRESP_ID_CHECK_EN
  // Registered ID-check pulse; routing still follows the stored index
  always_ff @(posedge clk) begin
    if (!rst_n) err_id_mismatch <= 1'b0;
    else        err_id_mismatch <= pop && (s_bid != head_id);
  end
`else
  assign err_id_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_axi_bresp_router.sv
// Bench for axi_bresp_router: queue-based reference model updated on every
// rising edge, a per-cycle compare process, directed scenarios with literal
// expectations, then a randomized phase with occasional resets.
module tb_axi_bresp_router;
  import axi_ic_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int ID_W  = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    gnt;
  logic            accept;
  logic [ID_W-1:0] aw_id;
  logic            full;
  logic [CW-1:0]   outstanding;
  logic            s_bvalid;
  logic            s_bready;
  logic [ID_W-1:0] s_bid;
  logic [1:0]      s_bresp;
  logic [N-1:0]    m_bvalid;
  logic [N-1:0]    m_bready;
  logic [ID_W-1:0] m_bid;
  logic [1:0]      m_bresp;
  logic            err_overflow;
  logic            err_unexpected;
  logic            err_id_mismatch;

  always #5 clk = ~clk;

  axi_bresp_router #(.N(N), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .gnt             (gnt),
    .accept          (accept),
    .aw_id           (aw_id),
    .full            (full),
    .outstanding     (outstanding),
    .s_bvalid        (s_bvalid),
    .s_bready        (s_bready),
    .s_bid           (s_bid),
    .s_bresp         (s_bresp),
    .m_bvalid        (m_bvalid),
    .m_bready        (m_bready),
    .m_bid           (m_bid),
    .m_bresp         (m_bresp),
    .err_overflow    (err_overflow),
    .err_unexpected  (err_unexpected),
    .err_id_mismatch (err_id_mismatch)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of outstanding writes plus the one pending response
  typedef struct { int idx; int id; } ent_t;
  ent_t q[$];
  bit   mv;
  int   midx, mbid, mbresp;
  bit   e_ovf, e_idm;

  function automatic int lowest(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  function automatic bit model_sready();
    return (q.size() > 0) && (!mv || m_bready[midx]);
  endfunction

  initial begin : model
    bit   p, a;
    ent_t h;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        mv = 0; midx = 0; mbid = 0; mbresp = 0; e_ovf = 0; e_idm = 0;
      end else begin
        p     = s_bvalid && model_sready();
        a     = accept && (gnt != 0);
        e_ovf = a && (q.size() == DEPTH) && !p;
        e_idm = 0;
        if (p) begin
          h = q.pop_front();
`ifdef AXI_BRESP_ID_CHECK_EN
          e_idm = (h.id != int'(s_bid));
`endif
          mv = 1; midx = h.idx; mbid = int'(s_bid); mbresp = int'(s_bresp);
        end else if (mv && m_bready[midx]) begin
          mv = 0;
        end
        if (a && (q.size() < DEPTH || p)) q.push_back('{lowest(gnt), int'(aw_id)});
      end
    end
  end

  // Every cycle: all outputs against the model, sampled mid-cycle
  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      chk("full",        full,        q.size() == DEPTH);
      chk("outstanding", outstanding, q.size());
      chk("s_bready",    s_bready,    model_sready());
      chk("m_bvalid",    m_bvalid,    mv ? (32'd1 << midx) : 32'd0);
      chk("m_bid",       m_bid,       mbid);
      chk("m_bresp",     m_bresp,     mbresp);
      chk("err_overflow",    err_overflow,    e_ovf);
      chk("err_unexpected",  err_unexpected,  s_bvalid && (q.size() == 0));
      chk("err_id_mismatch", err_id_mismatch, e_idm);
    end
  end

  task automatic cyc(input bit acc, input logic [N-1:0] g, input int id, input bit bv,
                     input int bid, input int br, input logic [N-1:0] mr);
    @(negedge clk);
    accept = acc; gnt = g; aw_id = ID_W'(id);
    s_bvalid = bv; s_bid = ID_W'(bid); s_bresp = 2'(br); m_bready = mr;
    #2;
  endtask

  task automatic idle();
    cyc(0, '0, 0, 0, 0, 0, '1);
  endtask

  initial begin : stim
    int bid;
    logic [N-1:0] g;
    int r;
    int acc_pct;
    rst_n = 0; accept = 0; gnt = '0; aw_id = '0;
    s_bvalid = 0; s_bid = '0; s_bresp = '0; m_bready = '1;

    // Reset values
    idle();
    chk("rst_s_bready", s_bready, 0);
    chk("rst_m_bvalid", m_bvalid, 0);
    chk("rst_m_bid", m_bid, 0);
    chk("rst_m_bresp", m_bresp, 0);
    chk("rst_full", full, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_errs", {err_overflow, err_unexpected, err_id_mismatch}, 0);
    idle();
    rst_n = 1;
    idle();

    // Ordering
    cyc(1, 4'b0010, 1, 0, 0, 0, '1);
    chk("ord_s_bready_push_cycle", s_bready, 0);
    cyc(1, 4'b1000, 2, 0, 0, 0, '1);
    chk("ord_outstanding1", outstanding, 1);
    cyc(1, 4'b0001, 3, 0, 0, 0, '1);
    chk("ord_outstanding2", outstanding, 2);
    cyc(0, '0, 0, 1, 1, OKAY, '1);
    chk("ord_outstanding3", outstanding, 3);
    chk("ord_s_bready", s_bready, 1);
    cyc(0, '0, 0, 1, 2, SLVERR, '1);
    chk("ord_mv0", m_bvalid, 4'b0010);
    chk("ord_resp0", m_bresp, 0);
    cyc(0, '0, 0, 1, 3, OKAY, '1);
    chk("ord_mv1", m_bvalid, 4'b1000);
    chk("ord_resp1", m_bresp, 2);
    idle();
    chk("ord_mv2", m_bvalid, 4'b0001);
    chk("ord_resp2", m_bresp, 0);
    idle();
    chk("ord_done_mv", m_bvalid, 0);
    chk("ord_done_out", outstanding, 0);

    // Backpressure on master 2
    cyc(1, 4'b0100, 4, 0, 0, 0, 4'b1011);
    cyc(1, 4'b0100, 5, 0, 0, 0, 4'b1011);
    cyc(0, '0, 0, 1, 4, OKAY, 4'b1011);
    chk("bp_first_sready", s_bready, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, '0, 0, 1, 5, EXOKAY, 4'b1011);
      chk("bp_hold_mv", m_bvalid, 4'b0100);
      chk("bp_hold_bid", m_bid, 4);
      chk("bp_hold_resp", m_bresp, 0);
      chk("bp_hold_sready", s_bready, 0);
    end
    cyc(0, '0, 0, 1, 5, EXOKAY, '1);
    chk("bp_release_sready", s_bready, 1);
    chk("bp_release_bid", m_bid, 4);
    idle();
    chk("bp_second_mv", m_bvalid, 4'b0100);
    chk("bp_second_bid", m_bid, 5);
    chk("bp_second_resp", m_bresp, 1);
    idle();
    chk("bp_done_mv", m_bvalid, 0);

    // Full and overflow
    for (int i = 0; i < DEPTH; i++) cyc(1, 4'b0001, i, 0, 0, 0, '1);
    cyc(1, 4'b0001, 9, 0, 0, 0, '1);
    chk("full_flag", full, 1);
    chk("full_outstanding", outstanding, 8);
    idle();
    chk("ovf_pulse", err_overflow, 1);
    chk("ovf_outstanding", outstanding, 8);
    cyc(1, 4'b0010, 10, 1, 0, OKAY, '1);
    chk("ovf_pulse_end", err_overflow, 0);
    chk("full_pushpop_sready", s_bready, 1);
    idle();
    chk("full_pushpop_out", outstanding, 8);
    chk("full_pushpop_ovf", err_overflow, 0);
    chk("full_pushpop_full", full, 1);
    chk("full_pushpop_mv", m_bvalid, 4'b0001);
    for (int i = 0; i < DEPTH; i++) cyc(0, '0, 0, 1, i + 1, OKAY, '1);
    idle();
    idle();
    chk("drain_out", outstanding, 0);
    chk("drain_mv", m_bvalid, 0);

    // Unexpected response with empty FIFO
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 0, 1, 0, OKAY, '1);
      chk("unexp_level", err_unexpected, 1);
      chk("unexp_sready", s_bready, 0);
      chk("unexp_mv", m_bvalid, 0);
    end
    idle();
    chk("unexp_clear", err_unexpected, 0);
    chk("unexp_no_mv", m_bvalid, 0);

    // ID check
    cyc(1, 4'b0100, 5, 0, 0, 0, '1);
    cyc(0, '0, 0, 1, 6, OKAY, '1);
    idle();
    chk("id_mv", m_bvalid, 4'b0100);
    chk("id_bid", m_bid, 6);
`ifdef AXI_BRESP_ID_CHECK_EN
    chk("id_pulse", err_id_mismatch, 1);
`else
    chk("id_tied", err_id_mismatch, 0);
`endif
    idle();
    chk("id_pulse_end", err_id_mismatch, 0);

    // Reset mid-operation: 3 queued, one held in the output stage
    for (int i = 0; i < 4; i++) cyc(1, 4'b0001, i, 0, 0, 0, '0);
    cyc(0, '0, 0, 1, 0, OKAY, '0);
    cyc(0, '0, 0, 0, 0, 0, '0);
    chk("mid_pre_out", outstanding, 3);
    chk("mid_pre_mv", m_bvalid, 4'b0001);
    rst_n = 0;
    cyc(0, '0, 0, 0, 0, 0, '0);
    chk("mid_rst_out", outstanding, 0);
    chk("mid_rst_mv", m_bvalid, 0);
    chk("mid_rst_sready", s_bready, 0);
    rst_n = 1;
    cyc(0, '0, 0, 0, 0, 0, '1);
    chk("mid_after_mv", m_bvalid, 0);

    // Randomized traffic, alternating fill-heavy and drain-heavy phases
    for (int c = 0; c < 3000; c++) begin
      acc_pct = ((c / 400) % 2 == 0) ? 75 : 25;
      r = int'($urandom_range(0, 9));
      if (r < 7)      g = N'(1 << $urandom_range(0, N-1));
      else if (r < 8) g = '0;
      else            g = N'($urandom);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) bid = q[0].id;
      else bid = int'($urandom_range(0, 15));
      cyc(int'($urandom_range(0, 99)) < acc_pct, g, int'($urandom_range(0, 15)),
          int'($urandom_range(0, 99)) >= acc_pct, bid, int'($urandom_range(0, 3)),
          N'($urandom));
      rst_n = ($urandom_range(0, 599) != 0);
    end
    rst_n = 1;
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
